lt_result_packer: RTL and testbench
===================================

# lt_result_packer

Downstream collector for the registered 16-bit less-than benchmark stage. It realigns a valid strobe with the stage's fixed pipeline latency and packs the qualified 1-bit `result` stream LSB-first into `WORD_WIDTH`-bit words. Completed or flushed words go into a small FIFO that is drained over a valid/ready interface. The upstream stage cannot be stalled, so words that find the FIFO full are dropped and counted in a sticky overflow flag.

## Interface
- `LATENCY`, 4: cycles from operands entering the upstream stage to their `result`; with one input/output pipeline stage this is 4.
- `WORD_WIDTH`, 16: result bits per packed word; must be at least 2.
- `FIFO_DEPTH`, 4: number of packed words buffered; must be at least 1.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: high in the cycle valid operands are presented to the upstream stage.
- `result` in 1: upstream less-than output, sampled only when the delayed `in_valid` is high.
- `flush` in 1: single-cycle request to emit the partial word.
- `out_valid` out 1: FIFO head word is available.
- `out_ready` in 1: consumer accepts the head word; a pop occurs when `out_valid && out_ready`.
- `out_data` out `WORD_WIDTH`: head word; bit i is the i-th qualified result; unused high bits are 0.
- `out_bits` out `$clog2(WORD_WIDTH+1)`: number of valid bits in `out_data` (1..`WORD_WIDTH`).
- `overflow` out 1: sticky; set when any word is dropped.

## Operation
- **Valid delay line:** `LATENCY`-deep shift register of `in_valid`. Its output `q` (valid delayed by `LATENCY` cycles) qualifies `result` in the same cycle.
- **Packing:** `pack` register plus `bit_cnt` (0..`WORD_WIDTH`-1).
  - On each edge with `q`=1: `pack[bit_cnt] <= result` and `bit_cnt` increments.
  - If that bit makes the count reach `WORD_WIDTH`, push {pack with the new bit, `WORD_WIDTH`}, then clear `pack` and `bit_cnt` to 0.
- **Flush:** on an edge with `flush`=1 where the effective count (including the bit qualified by `q` in that cycle) is between 1 and `WORD_WIDTH`-1:
  - push {partial word, zero-padded; effective count};
  - clear `pack` and `bit_cnt`.
- **Flush no-ops:** flush with effective count 0 does nothing. Flush on the same edge that completes a full word pushes only the full word.
- **FIFO:** registered storage with first-word fall-through. A push is accepted when occupancy < `FIFO_DEPTH`, or when the FIFO is full and a pop occurs on the same edge. Otherwise the word is discarded and `overflow` is set to 1. Packing is unaffected either way.
- **Ordering:** words leave in push order. Simultaneous push and pop leaves occupancy unchanged.
- **Quiet output:** while `out_valid`=0, `out_data` and `out_bits` are 0.
- **Overflow clear:** `overflow` clears only on reset.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `out_bits`=0, `overflow`=0. The delay line, `pack`, `bit_cnt` and FIFO pointers/occupancy are all cleared.
- **Reset mid-operation:** discards the partial word, all in-flight valids and all buffered words. The first `q` can only come from an `in_valid` sampled after `rst_n` deasserts.
- **Input-to-result alignment:** `in_valid` sampled at edge t qualifies `result` in cycle t+`LATENCY`.
- **Output latency:** a word pushed at edge e has `out_valid`=1 from cycle e+1 when the FIFO was empty. The final result bit is therefore visible as a word one cycle later.
- **Throughput:**
  - One result bit per cycle sustained.
  - One push per edge maximum.
  - One pop per cycle when `out_ready` is held high.
- **Handshake stability:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_bits` hold stable.
- **Wrap-around:** FIFO pointers wrap modulo `FIFO_DEPTH`, and full/empty are distinguished by the occupancy count. `bit_cnt` wraps `WORD_WIDTH`-1 → 0 only on a push.

## Test plan
1. **Reset:** assert `rst_n`=0 asynchronously mid-cycle, with no clock edge → `out_valid`=0, `out_data`=0, `out_bits`=0, `overflow`=0 immediately.
2. **Full word:** `in_valid`=1 for cycles 0–15; `result` = 1,0,1,0,… in cycles 4–19; `out_ready`=1 → `out_valid` rises in cycle 20 with `out_data`=0x5555 and `out_bits`=16, for exactly one cycle.
3. **Gapped valid:**
   - `in_valid` alternates 1/0 over 32 cycles.
   - `result`=1 in unqualified cycles and 0 in qualified cycles.
   - → one word 0x0000 with `out_bits`=16; no other output.
4. **Flush:**
   - 5 qualified bits all 1, then `flush` two cycles later → `out_data`=0x001F, `out_bits`=5.
   - A second `flush` right after → no output.
   - `flush` in the same cycle as the 16th qualified bit → only one word, `out_bits`=16.
5. **Overflow:**
   - `out_ready`=0 with 80 consecutive qualified bits, `result` = word index k in bits 0..3 → words 0–3 stored; word 4 is dropped and `overflow`=1.
   - Then `out_ready`=1 → `out_data` 0x0000, 0x0001, 0x0002, 0x0003 in order, and `overflow` stays 1.
6. **Reset mid-word:**
   - 7 bits packed and 3 valids in flight; pulse `rst_n` low for 2 cycles.
   - Then 16 new qualified bits all 1 → a single word 0xFFFF with `out_bits`=16; nothing from before the reset appears.

Source files
------------

// File: rtl/lt_result_packer.sv
// lt_result_packer
//
// Collects the 1-bit result stream of the registered 16-bit less-than stage.
// The upstream valid strobe is delayed by LATENCY cycles so it lines up with
// the matching result. Qualified results are packed LSB-first into
// WORD_WIDTH-bit words. Each full word, or each partial word emitted by a
// flush, is written to a first-word fall-through FIFO. The upstream stage
// cannot stall, so a word that finds the FIFO full is dropped and sets a
// sticky overflow flag.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   operands presented to the upstream stage this cycle
//   result_i     upstream less-than result, used only when the delayed valid is high
//   flush_i      single-cycle request to emit the partial word
//   out_valid_o  FIFO head word available
//   out_ready_i  consumer accepts the head word
//   out_data_o   head word, bit i = i-th packed result, unused high bits 0
//   out_bits_o   number of valid bits in out_data_o (1..WORD_WIDTH)
//   overflow_o   sticky, set when any word is dropped
//
// Handshake: a word transfers on every rising edge where out_valid_o and
// out_ready_i are both high. While out_valid_o is high and out_ready_i is low,
// out_data_o and out_bits_o hold stable. While out_valid_o is low, both are 0.
module lt_result_packer #(
    parameter  int LATENCY    = 4,
    parameter  int WORD_WIDTH = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int BITS_W     = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic                  result_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic [BITS_W-1:0]     out_bits_o,
    output logic                  overflow_o
);

    localparam int CNT_W = $clog2(WORD_WIDTH);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    // Valid delay line
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [LATENCY:0]      vld_shift;
    logic                  q_valid;

    // Packing state
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] pack_with_bit;
    logic [BITS_W-1:0]     eff_cnt;
    logic                  word_full;
    logic                  push;

    // FIFO state
    logic [WORD_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [BITS_W-1:0]     bits_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  accept;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // The extra low bit lets the same expression serve LATENCY == 1.
    assign vld_shift = {vld_q, in_valid_i};
    assign vld_d     = vld_shift[LATENCY-1:0];
    assign q_valid   = vld_q[LATENCY-1];

    always_comb begin
        pack_with_bit = pack_q;
        if (q_valid) begin
            pack_with_bit[bit_cnt_q] = result_i;
        end
        // Count including the bit qualified this cycle. It equals WORD_WIDTH
        // exactly when the word completes, so it doubles as the pushed length.
        eff_cnt   = BITS_W'(bit_cnt_q) + BITS_W'(q_valid);
        word_full = q_valid && (bit_cnt_q == CNT_W'(WORD_WIDTH - 1));
        // A flush on the completing edge adds nothing: the full word is pushed.
        push      = word_full || (flush_i && (eff_cnt != '0));

        pack_d    = pack_q;
        bit_cnt_d = bit_cnt_q;
        if (push) begin
            pack_d    = '0;
            bit_cnt_d = '0;
        end else if (q_valid) begin
            pack_d    = pack_with_bit;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid_o = (occ_q != '0);
    assign pop         = out_valid_o && out_ready_i;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign accept      = push && ((occ_q != OCC_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        wr_ptr_d   = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d      = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
        overflow_d = overflow_q || (push && !accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            pack_q     <= '0;
            bit_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            pack_q     <= pack_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the outputs are gated by out_valid_o.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[wr_ptr_q] <= pack_with_bit;
            bits_mem[wr_ptr_q] <= eff_cnt;
        end
    end

    assign out_data_o = out_valid_o ? data_mem[rd_ptr_q] : '0;
    assign out_bits_o = out_valid_o ? bits_mem[rd_ptr_q] : '0;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_lt_result_packer.sv
module tb_lt_result_packer;

    localparam int L  = 4;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int BW = $clog2(W + 1);
    localparam int EW = BW + W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          result;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [BW-1:0] out_bits;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    // Scoreboard: {bits, data} of every word the model says the FIFO accepted
    logic [EW-1:0] exp_q[$];
    logic          exp_ovf;

    // Reference model state
    bit            vhist[$];   // in_valid sampled on recent edges
    bit            bit_q[$];   // qualified results not yet emitted
    int            mdl_occ;

    lt_result_packer #(
        .LATENCY   (L),
        .WORD_WIDTH(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .result_i   (result),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_bits_o (out_bits),
        .overflow_o (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Asserts reset mid-cycle, away from any edge, and checks outputs at once.
    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        result    = 1'b0;
        flush     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_bits",  32'(out_bits),  32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic iv, input logic r, input logic f, input logic rdy);
        @(posedge clk);
        #1;
        in_valid  = iv;
        result    = r;
        flush     = f;
        out_ready = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy);
    endtask

    // ---------------- reference model ----------------
    // Behaviour per edge: result qualified by the in_valid seen L edges ago,
    // bits collected in a list, a word emitted at W bits or on flush, the
    // word kept if the FIFO has room (counting a same-edge pop).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vhist.delete();
            bit_q.delete();
            exp_q.delete();
            mdl_occ = 0;
            exp_ovf = 1'b0;
        end else begin
            bit             qv;
            bit             pop_m;
            bit             have_word;
            logic [W-1:0]   wdata;
            logic [BW-1:0]  wbits;
            qv    = (vhist.size() >= L) ? vhist[vhist.size() - L] : 1'b0;
            pop_m = (mdl_occ > 0) && out_ready;
            vhist.push_back(in_valid);
            if (vhist.size() > L) void'(vhist.pop_front());
            if (qv) bit_q.push_back(result);
            have_word = 1'b0;
            wdata     = '0;
            wbits     = '0;
            if (bit_q.size() == W || (flush && bit_q.size() > 0)) begin
                for (int i = 0; i < bit_q.size(); i++) wdata[i] = bit_q[i];
                wbits = BW'(bit_q.size());
                bit_q.delete();
                have_word = 1'b1;
            end
            if (have_word) begin
                if (mdl_occ < D || pop_m) begin
                    exp_q.push_back({wbits, wdata});
                    mdl_occ++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (pop_m) mdl_occ--;
        end
    end

    // ---------------- monitor ----------------
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [EW-1:0] prev_word  = '0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic [EW-1:0] e;
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid !== 1'b1) begin
                check("quiet", 32'({out_bits, out_data}), 32'd0);
            end else if (prev_valid && !prev_ready) begin
                check("stable", 32'({out_bits, out_data}), 32'(prev_word));
            end
            if (out_valid === 1'b1 && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("word", 32'({out_bits, out_data}), 32'(e));
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_word  = {out_bits, out_data};
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        result    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3, 1'b1);

        // Asynchronous reset with no edge involved
        do_reset();
        idle(2, 1'b1);

        // Full word of alternating results: expected 0x5555, 16 bits
        for (int i = 0; i < 24; i++)
            step(i < 16, (i >= 4 && i < 20) ? ((i % 2) == 0) : 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Gapped valid: qualified results are 0, unqualified are 1
        for (int i = 0; i < 38; i++)
            step((i < 32) && (i % 2 == 0), !((i >= 4) && (i % 2 == 0)), 1'b0, 1'b1);
        idle(4, 1'b1);

        // Five ones, flush two cycles after the last, then a second flush
        for (int i = 0; i < 14; i++)
            step(i < 5, 1'b1, (i == 10) || (i == 11), 1'b1);
        idle(4, 1'b1);

        // Flush coinciding with the 16th qualified bit
        for (int i = 0; i < 24; i++)
            step(i < 16, 1'($urandom_range(0, 1)), i == 19, 1'b1);
        idle(4, 1'b1);

        // Overflow: 80 bits with consumer stalled; word k carries k in bits 0..3
        for (int i = 0; i < 90; i++) begin
            int n;
            logic [3:0] k;
            n = i - 4;
            k = 4'(n / 16);
            step(i < 80, (n >= 0 && (n % 16) < 4) ? k[n % 16] : 1'b0, 1'b0, 1'b0);
        end
        idle(8, 1'b1);

        // Reset with 7 bits packed and 3 valids in flight
        for (int i = 0; i < 11; i++)
            step(i < 10, 1'b1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 24; i++)
            step(i < 16, 1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic, including stalled stretches
        for (int i = 0; i < 900; i++) begin
            logic rdy;
            rdy = (((i / 60) % 3) == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, rdy);
        end

        // Drain: stop input, flush the remainder, let the FIFO empty
        idle(L + 1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(D + 6, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
